// File: rtl/cv_spinner_quad.sv
// cv_spinner_quad
// Converts signed spinner deltas from a roller controller into a paced
// two-phase quadrature stream, like a mechanical roller on the console pins.
// Each event on spinner_i adds its delta to a saturating signed accumulator.
// A free-running step timer then drains the accumulator one quadrature step
// per STEP_DIV enabled ticks.
//
// Parameters
//   STEP_DIV : enabled ticks between quadrature steps (2..65535)
//   ACC_W    : signed pending-count accumulator width (9..16)
// Ports
//   clk_i         : system clock (single domain)
//   reset_n_i     : asynchronous active-low reset
//   clk_en_10m7_i : 10.7 MHz clock enable; the step timer advances only on it
//   enable_i      : roller controller attached; 0 forces idle
//   invert_i      : negate incoming deltas
//   spinner_i     : [7:0] signed delta, [8] toggles once per event
//   p7_o          : quadrature phase A (console interrupt line)
//   p9_o          : quadrature phase B (direction line)
//   busy_o        : accumulator non-zero
//   step_o        : one-cycle pulse per emitted quadrature step
module cv_spinner_quad #(
  parameter int STEP_DIV = 1024,
  parameter int ACC_W    = 12
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       clk_en_10m7_i,
  input  logic       enable_i,
  input  logic       invert_i,
  input  logic [8:0] spinner_i,
  output logic       p7_o,
  output logic       p9_o,
  output logic       busy_o,
  output logic       step_o
);

  // Two guard bits cover acc + delta(+/-128) - step without overflow.
  localparam int SUM_W = ACC_W + 2;
  localparam logic [15:0]             TMR_LAST = 16'(STEP_DIV - 1);
  localparam logic signed [SUM_W-1:0] ACC_MAX  = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN  = -ACC_MAX;

  // Clamp a wide sum into the symmetric accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
    if (v > ACC_MAX) begin
      sat_acc = ACC_MAX[ACC_W-1:0];
    end else if (v < ACC_MIN) begin
      sat_acc = ACC_MIN[ACC_W-1:0];
    end else begin
      sat_acc = v[ACC_W-1:0];
    end
  endfunction

  // Gray mapping of the 2-bit phase onto {p9, p7}.
  function automatic logic [1:0] phase_to_pins(input logic [1:0] ph);
    case (ph)
      2'd0:    phase_to_pins = 2'b11;
      2'd1:    phase_to_pins = 2'b10;
      2'd2:    phase_to_pins = 2'b00;
      2'd3:    phase_to_pins = 2'b01;
      default: phase_to_pins = 2'b11;
    endcase
  endfunction

  logic                    tgl_r;
  logic                    armed_r;
  logic [15:0]             timer_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [1:0]              phase_r;
  logic [1:0]              pins_r;
  logic                    busy_r;
  logic                    step_r;

  logic                    event_s;
  logic                    tick_s;
  logic                    acc_pos_s;
  logic signed [8:0]       delta_raw_s;
  logic signed [8:0]       delta_s;
  logic signed [SUM_W-1:0] acc_ext_s;
  logic signed [SUM_W-1:0] delta_ext_s;
  logic signed [SUM_W-1:0] adj_s;
  logic signed [SUM_W-1:0] sum_s;
  logic signed [ACC_W-1:0] acc_nxt_s;
  logic [1:0]              phase_nxt_s;

  // Event detection, step tick and next accumulator/phase.
  always_comb begin
    event_s     = armed_r && (tgl_r != spinner_i[8]) && enable_i;
    delta_raw_s = $signed({spinner_i[7], spinner_i[7:0]});
    // 9 bits so that -(-128) is representable as +128.
    if (invert_i) begin
      delta_s = -delta_raw_s;
    end else begin
      delta_s = delta_raw_s;
    end
    tick_s      = clk_en_10m7_i && (timer_r == TMR_LAST) &&
                  (acc_r != {ACC_W{1'b0}}) && enable_i;
    acc_pos_s   = !acc_r[ACC_W-1];
    acc_ext_s   = $signed({{(SUM_W-ACC_W){acc_r[ACC_W-1]}}, acc_r});
    if (event_s) begin
      delta_ext_s = $signed({{(SUM_W-9){delta_s[8]}}, delta_s});
    end else begin
      delta_ext_s = {SUM_W{1'b0}};
    end
    // Step direction comes from the accumulator before this cycle's update.
    if (!tick_s) begin
      adj_s = {SUM_W{1'b0}};
    end else if (acc_pos_s) begin
      adj_s = $signed({{(SUM_W-1){1'b0}}, 1'b1});
    end else begin
      adj_s = {SUM_W{1'b1}};
    end
    sum_s = acc_ext_s + delta_ext_s - adj_s;
    if (!enable_i) begin
      acc_nxt_s   = {ACC_W{1'b0}};
      phase_nxt_s = 2'd0;
    end else begin
      acc_nxt_s = sat_acc(sum_s);
      if (!tick_s) begin
        phase_nxt_s = phase_r;
      end else if (acc_pos_s) begin
        phase_nxt_s = phase_r + 2'd1;
      end else begin
        phase_nxt_s = phase_r - 2'd1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tgl_r   <= 1'b0;
      armed_r <= 1'b0;
      timer_r <= 16'd0;
      acc_r   <= {ACC_W{1'b0}};
      phase_r <= 2'd0;
      pins_r  <= 2'b11;
      busy_r  <= 1'b0;
      step_r  <= 1'b0;
    end else begin
      // The first cycle after reset only captures the toggle bit.
      tgl_r   <= spinner_i[8];
      armed_r <= 1'b1;
      if (clk_en_10m7_i) begin
        timer_r <= (timer_r == TMR_LAST) ? 16'd0 : timer_r + 16'd1;
      end else begin
        timer_r <= timer_r;
      end
      acc_r   <= acc_nxt_s;
      phase_r <= phase_nxt_s;
      pins_r  <= phase_to_pins(phase_nxt_s);
      busy_r  <= (acc_nxt_s != {ACC_W{1'b0}});
      step_r  <= tick_s;
    end
  end

  assign p9_o   = pins_r[1];
  assign p7_o   = pins_r[0];
  assign busy_o = busy_r;
  assign step_o = step_r;

endmodule

// File: tb/tb_cv_spinner_quad.sv
// Testbench for cv_spinner_quad: directed scenarios plus randomized traffic,
// every cycle compared against an integer reference model of the roller.
module tb_cv_spinner_quad;

  localparam int STEP_DIV = 4;
  localparam int ACC_W    = 9;
  localparam int ACC_MAX  = 255;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       clk_en_10m7_i;
  logic       enable_i;
  logic       invert_i;
  logic [8:0] spinner_i;
  logic       p7_o;
  logic       p9_o;
  logic       busy_o;
  logic       step_o;

  cv_spinner_quad #(.STEP_DIV(STEP_DIV), .ACC_W(ACC_W)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .clk_en_10m7_i (clk_en_10m7_i),
    .enable_i      (enable_i),
    .invert_i      (invert_i),
    .spinner_i     (spinner_i),
    .p7_o          (p7_o),
    .p9_o          (p9_o),
    .busy_o        (busy_o),
    .step_o        (step_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: pending count, quadrature position, timer.
  int m_acc;
  int m_phase;
  int m_timer;
  bit m_armed;
  bit m_prev;
  bit m_step;

  int         step_cnt;
  logic [1:0] step_pins[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] pins_of(input int ph);
    logic [1:0] gray [0:3];
    gray[0] = 2'b11; gray[1] = 2'b10; gray[2] = 2'b00; gray[3] = 2'b01;
    return gray[ph];
  endfunction

  function automatic logic [1:0] qget(input int i);
    if (i < step_pins.size()) return step_pins[i];
    return 2'bxx;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_phase = 0; m_timer = 0; m_armed = 0; m_prev = 0; m_step = 0;
  endtask

  // One clock edge of the roller as described behaviourally.
  task automatic model_edge();
    bit ev, tick;
    int d, s, t;
    ev      = m_armed && (m_prev != spinner_i[8]) && enable_i;
    m_prev  = spinner_i[8];
    m_armed = 1;
    d = int'($signed(spinner_i[7:0]));
    if (invert_i) d = -d;
    tick = clk_en_10m7_i && (m_timer == STEP_DIV - 1) && (m_acc != 0) && enable_i;
    if (clk_en_10m7_i) m_timer = (m_timer + 1) % STEP_DIV;
    if (!enable_i) begin
      m_acc = 0; m_phase = 0; m_step = 0;
    end else begin
      s = 0;
      if (tick) s = (m_acc > 0) ? 1 : -1;
      m_phase = (m_phase + s + 4) % 4;
      t = m_acc + (ev ? d : 0) - s;
      if (t > ACC_MAX) t = ACC_MAX;
      if (t < -ACC_MAX) t = -ACC_MAX;
      m_acc  = t;
      m_step = tick;
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    model_edge();
    #1;
    chk("cycle", {p9_o, p7_o, busy_o, step_o}, {pins_of(m_phase), m_acc != 0, m_step});
    if (step_o) begin
      step_cnt++;
      step_pins.push_back({p9_o, p7_o});
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [7:0] d, input logic inv);
    spinner_i = {~spinner_i[8], d};
    invert_i  = inv;
    cyc();
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk_i);
      #1;
      chk("reset_state", {p9_o, p7_o, busy_o, step_o}, 4'b1100);
    end
    reset_n_i = 1'b1;
    step_cnt  = 0;
    step_pins.delete();
  endtask

  initial begin
    int guard;
    reset_n_i     = 1'b0;
    clk_en_10m7_i = 1'b1;
    enable_i      = 1'b1;
    invert_i      = 1'b0;
    spinner_i     = 9'h000;
    #2;

    // +3 from phase 0: 10, 00, 01 then idle
    do_reset();
    run(3);
    send(8'h03, 1'b0);
    run(20);
    chk("p3_steps", step_cnt, 3);
    chk("p3_pin0", qget(0), 2'b10);
    chk("p3_pin1", qget(1), 2'b00);
    chk("p3_pin2", qget(2), 2'b01);
    chk("p3_busy", busy_o, 1'b0);

    // -2 from phase 0: 01, 00
    do_reset();
    run(2);
    send(8'hFE, 1'b0);
    run(16);
    chk("m2_steps", step_cnt, 2);
    chk("m2_pin0", qget(0), 2'b01);
    chk("m2_pin1", qget(1), 2'b00);
    chk("m2_busy", busy_o, 1'b0);

    // Saturation: three +127 events with the timer frozen
    do_reset();
    run(2);
    clk_en_10m7_i = 1'b0;
    send(8'h7F, 1'b0);
    send(8'h7F, 1'b0);
    send(8'h7F, 1'b0);
    chk("sat_busy", busy_o, 1'b1);
    clk_en_10m7_i = 1'b1;
    step_cnt = 0;
    run(255 * STEP_DIV + 12);
    chk("sat_steps", step_cnt, 255);
    chk("sat_pins", {p9_o, p7_o}, 2'b01);
    chk("sat_busy_end", busy_o, 1'b0);

    // acc=+1 with +5 arriving on the tick cycle
    do_reset();
    run(2);
    clk_en_10m7_i = 1'b0;
    send(8'h01, 1'b0);
    clk_en_10m7_i = 1'b1;
    guard = 0;
    while (m_timer != STEP_DIV - 1 && guard < 8) begin
      cyc();
      guard++;
    end
    chk("coin_no_early_step", step_cnt, 0);
    send(8'h05, 1'b0);
    chk("coin_step", step_o, 1'b1);
    chk("coin_pins", {p9_o, p7_o}, 2'b10);
    chk("coin_busy", busy_o, 1'b1);
    step_cnt = 0;
    run(30);
    chk("coin_more_steps", step_cnt, 5);
    chk("coin_final_pins", {p9_o, p7_o}, 2'b00);

    // Toggle bit high through reset release: no spurious event
    spinner_i = 9'h100;
    do_reset();
    run(10);
    chk("arm_steps", step_cnt, 0);
    chk("arm_busy", busy_o, 1'b0);
    send(8'h02, 1'b1);
    run(16);
    chk("inv_steps", step_cnt, 2);
    chk("inv_pin0", qget(0), 2'b01);
    chk("inv_pin1", qget(1), 2'b00);
    invert_i = 1'b0;

    // Reset pulse during motion
    do_reset();
    run(2);
    send(8'h0A, 1'b0);
    run(9);
    chk("mid_busy", busy_o, 1'b1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_pins", {p9_o, p7_o}, 2'b11);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_step", step_o, 1'b0);
    model_reset();
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    step_cnt  = 0;
    run(20);
    chk("mid_no_steps", step_cnt, 0);
    chk("mid_idle_busy", busy_o, 1'b0);

    // Randomized traffic
    do_reset();
    run(2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 15) == 0) spinner_i = {~spinner_i[8], 8'h80};
        else spinner_i = {~spinner_i[8], 8'($urandom)};
      end
      invert_i      = 1'($urandom);
      enable_i      = ($urandom_range(0, 31) != 0);
      clk_en_10m7_i = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
